// File: rtl/my_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : my_adder_pkg
// Brief  : Shared widths, result type and reference add function for my_adder.
// Rev    : 1.0  initial release
// ============================================================================
package my_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] operand_t;

    typedef struct packed {
        logic     carry;
        operand_t sum;
    } result_t;

    function automatic result_t add_f(input operand_t a, input operand_t b);
        result_t r;
        r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_adder_if.sv
`default_nettype none
// ============================================================================
// Module : adder_if / clk_if
// Brief  : Signal bundles carrying the adder operands/results and its clock.
// Rev    : 1.0  initial release
// ============================================================================
interface adder_if #(
    parameter int WIDTH = 8
);
    logic             rstn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
endinterface

interface clk_if;
    logic clk;
endinterface
`default_nettype wire

// File: rtl/my_adder_rca.sv
`default_nettype none
// ============================================================================
// Module : my_adder_rca
// Brief  : Ripple-carry chain of full adders; MSB carry-in exported when
//          MY_ADDER_OVF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module my_adder_rca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef MY_ADDER_OVF_EN
    output logic             o_msb_cin,
`endif
    output logic [WIDTH-1:0] o_sum_next,
    output logic             o_carry_next
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = 1'b0;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            logic w_p;
            assign w_p           = i_a[i] ^ i_b[i];
            assign o_sum_next[i] = w_p ^ w_c[i];
            assign w_c[i+1]      = (i_a[i] & i_b[i]) | (w_p & w_c[i]);
        end
    endgenerate

    assign o_carry_next = w_c[WIDTH];

`ifdef MY_ADDER_OVF_EN
    assign o_msb_cin = w_c[WIDTH-1];
`endif

endmodule
`default_nettype wire

// File: rtl/my_adder.sv
`default_nettype none
// ============================================================================
// Module : my_adder
// Brief  : Registered unsigned adder, 1-cycle latency, async active-low reset.
//          Optional signed-overflow output enabled by MY_ADDER_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module my_adder
    import my_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MY_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH-1:0] w_sum_next;
    logic             w_carry_next;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

`ifdef MY_ADDER_OVF_EN
    logic w_msb_cin;
    logic r_ovf;
`endif

    my_adder_rca #(
        .WIDTH(WIDTH)
    ) u_rca (
        .i_a         (a),
        .i_b         (b),
`ifdef MY_ADDER_OVF_EN
        .o_msb_cin   (w_msb_cin),
`endif
        .o_sum_next  (w_sum_next),
        .o_carry_next(w_carry_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_sum   <= w_sum_next;
            r_carry <= w_carry_next;
        end
    end

`ifdef MY_ADDER_OVF_EN
    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_msb_cin ^ w_carry_next;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_my_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_my_adder
// Brief  : Self-checking bench for my_adder (ovf checked when MY_ADDER_OVF_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_my_adder;

    localparam int W = 8;

    clk_if             cif ();
    adder_if #(.WIDTH(W)) aif ();

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Reference model state: what the outputs must read right now.
    logic [W-1:0] exp_sum;
    logic         exp_carry;
    logic         exp_ovf;

    my_adder #(
        .WIDTH(W)
    ) dut (
        .clk  (cif.clk),
        .rstn (aif.rstn),
        .a    (aif.a),
        .b    (aif.b),
`ifdef MY_ADDER_OVF_EN
        .ovf  (aif.ovf),
`endif
        .sum  (aif.sum),
        .carry(aif.carry)
    );

`ifndef MY_ADDER_OVF_EN
    assign aif.ovf = 1'b0;
`endif

    initial cif.clk = 1'b0;
    always #5 cif.clk = ~cif.clk;

    function automatic int to_signed(input logic [W-1:0] v);
        int x;
        x = int'(v);
        if (x >= (1 << (W - 1))) x = x - (1 << W);
        return x;
    endfunction

    always @(posedge cif.clk or negedge aif.rstn) begin
        if (!aif.rstn) begin
            exp_sum   = '0;
            exp_carry = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            int total;
            int stotal;
            total     = int'(aif.a) + int'(aif.b);
            stotal    = to_signed(aif.a) + to_signed(aif.b);
            exp_sum   = W'(total % (1 << W));
            exp_carry = (total >= (1 << W));
            exp_ovf   = (stotal > (1 << (W - 1)) - 1) || (stotal < -(1 << (W - 1)));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge cif.clk) begin
        if (cmp_en) begin
            chk("model_sum", 64'(aif.sum), 64'(exp_sum));
            chk("model_carry", 64'(aif.carry), 64'(exp_carry));
`ifdef MY_ADDER_OVF_EN
            chk("model_ovf", 64'(aif.ovf), 64'(exp_ovf));
`endif
        end
    end

    // Drive operands now, then check the outputs just after the next edge.
    task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] es, input logic ec, input string nm);
        aif.a = ia;
        aif.b = ib;
        @(posedge cif.clk);
        #1;
        chk({nm, "_sum"}, 64'(aif.sum), 64'(es));
        chk({nm, "_carry"}, 64'(aif.carry), 64'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        aif.rstn = 1'b0;
        aif.a    = 8'h55;
        aif.b    = 8'h22;
        #1;
        chk("reset_sum_t0", 64'(aif.sum), 64'h0);
        cmp_en = 1'b1;
        repeat (3) @(posedge cif.clk);
        #1;
        chk("reset_sum", 64'(aif.sum), 64'h0);
        chk("reset_carry", 64'(aif.carry), 64'h0);

        aif.rstn = 1'b1;
        step(8'h03, 8'h04, 8'h07, 1'b0, "add_3_4");
        step(8'hFF, 8'h01, 8'h00, 1'b1, "wrap_ff_01");
        step(8'hFF, 8'hFF, 8'hFE, 1'b1, "max_ff_ff");
        step(8'd10, 8'd20, 8'd30, 1'b0, "b2b_10_20");
        step(8'd100, 8'd200, 8'd44, 1'b1, "b2b_100_200");
        step(8'd0, 8'd0, 8'd0, 1'b0, "b2b_0_0");
        step(8'h0F, 8'h0F, 8'h1E, 1'b0, "pre_reset");

        // Mid-cycle reset: outputs must clear without an edge.
        #3;
        aif.rstn = 1'b0;
        #1;
        chk("async_rst_sum", 64'(aif.sum), 64'h0);
        chk("async_rst_carry", 64'(aif.carry), 64'h0);
        aif.a = 8'h21;
        aif.b = 8'h02;
        #1;
        aif.rstn = 1'b1;
        @(posedge cif.clk);
        #1;
        chk("post_rst_sum", 64'(aif.sum), 64'h23);
        chk("post_rst_carry", 64'(aif.carry), 64'h0);

        step(8'h7F, 8'h01, 8'h80, 1'b0, "ovf_7f_01");
`ifdef MY_ADDER_OVF_EN
        chk("ovf_7f_01_ovf", 64'(aif.ovf), 64'h1);
`endif
        step(8'h80, 8'h80, 8'h00, 1'b1, "ovf_80_80");
`ifdef MY_ADDER_OVF_EN
        chk("ovf_80_80_ovf", 64'(aif.ovf), 64'h1);
`endif

        for (int i = 0; i < 400; i++) begin
            aif.a = W'($urandom);
            aif.b = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                #3;
                aif.rstn = 1'b0;
                #2;
                aif.rstn = 1'b1;
            end
            @(posedge cif.clk);
            #1;
        end

        @(negedge cif.clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
